// File: rtl/cosim_cycle_snapshot_queue.sv
// Snapshot queue between the cosim cycle-count request and response endpoints.
// Optional per-request sequence tag enabled by defining COSIM_SNAP_SEQ_EN.
module cosim_cycle_snapshot_queue #(
    parameter int              DEPTH                   = 4,
    parameter longint unsigned CORE_CLOCK_FREQUENCY_HZ = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] cycle_count,
    input  logic        req_valid,
    output logic        req_ready,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_cycle,
`ifdef COSIM_SNAP_SEQ_EN
    output logic [15:0] resp_seq,
`endif
    output logic [63:0] resp_freq
);

    localparam int             AW         = $clog2(DEPTH);
    localparam logic [AW:0]    FULL_COUNT = (AW + 1)'(DEPTH);

    logic [AW-1:0] rd_ptr_reg;
    logic [AW-1:0] wr_ptr_reg;
    logic [AW:0]   count_reg;
    logic [63:0]   cycle_mem [DEPTH];
    logic          push;
    logic          pop;

    // req_ready sees only the reset pin and registered occupancy, never resp_ready,
    // so a full queue refuses a push even when a pop lands on the same edge.
    assign req_ready  = !rst && (count_reg != FULL_COUNT);
    assign resp_valid = (count_reg != '0);
    assign push       = req_valid && req_ready;
    assign pop        = resp_valid && resp_ready;
    assign resp_freq  = CORE_CLOCK_FREQUENCY_HZ;
    assign resp_cycle = resp_valid ? cycle_mem[rd_ptr_reg] : 64'd0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + (AW + 1)'(1);
                2'b01:   count_reg <= count_reg - (AW + 1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Entries hold the count sampled on the accepting edge; stale contents are
    // masked by resp_valid, so storage needs no reset.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cycle_entry
            always_ff @(posedge clk) begin
                if (push && (wr_ptr_reg == AW'(gi))) begin
                    cycle_mem[gi] <= cycle_count;
                end
            end
        end
    endgenerate

`ifdef COSIM_SNAP_SEQ_EN
    logic [15:0] seq_reg;
    logic [15:0] seq_mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seq_reg <= 16'd0;
        end else if (push) begin
            seq_reg <= seq_reg + 16'd1;
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_seq_entry
            always_ff @(posedge clk) begin
                if (push && (wr_ptr_reg == AW'(gi))) begin
                    seq_mem[gi] <= seq_reg;
                end
            end
        end
    endgenerate

    assign resp_seq = resp_valid ? seq_mem[rd_ptr_reg] : 16'd0;
`endif

endmodule

// File: tb/tb_cosim_cycle_snapshot_queue.sv
// Randomized and directed bench for cosim_cycle_snapshot_queue against a queue model.
// Checks resp_seq as well when COSIM_SNAP_SEQ_EN is defined.
module tb_cosim_cycle_snapshot_queue;

    localparam int          DEPTH = 4;
    localparam logic [63:0] FREQ  = 64'd100_000_000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] cycle_count = 64'd0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [63:0] resp_cycle;
    logic [63:0] resp_freq;
`ifdef COSIM_SNAP_SEQ_EN
    logic [15:0] resp_seq;
`endif

    int checks = 0;
    int passes = 0;

    logic [63:0] mq[$];
    logic [15:0] sq[$];
    logic [15:0] mseq = 16'd0;

    always #5 clk = ~clk;

    cosim_cycle_snapshot_queue #(
        .DEPTH(DEPTH),
        .CORE_CLOCK_FREQUENCY_HZ(FREQ)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cycle_count(cycle_count),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_cycle(resp_cycle),
`ifdef COSIM_SNAP_SEQ_EN
        .resp_seq(resp_seq),
`endif
        .resp_freq(resp_freq)
    );

    // Advance one clock from posedge+1 to the next posedge+1, updating the model.
    task automatic cycle();
        bit          push;
        bit          pop;
        logic [63:0] cap;
        push = req_valid && (mq.size() < DEPTH) && !rst;
        pop  = resp_ready && (mq.size() > 0) && !rst;
        cap  = cycle_count;
        @(posedge clk);
        #1;
        if (pop) void'(mq.pop_front());
        if (pop) void'(sq.pop_front());
        if (push) begin
            mq.push_back(cap);
            sq.push_back(mseq);
            mseq = mseq + 16'd1;
        end
        cycle_count = cycle_count + 64'd1;
    endtask

    task automatic model_reset();
        mq.delete();
        sq.delete();
        mseq = 16'd0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (req_ready !== 1'b0) $display("FAIL reset_req_ready got=%b want=0", req_ready); else passes++;
        checks++; if (resp_valid !== 1'b0) $display("FAIL reset_resp_valid got=%b want=0", resp_valid); else passes++;
        checks++; if (resp_cycle !== 64'd0) $display("FAIL reset_resp_cycle got=%h want=0", resp_cycle); else passes++;
        checks++; if (resp_freq !== FREQ) $display("FAIL reset_resp_freq got=%0d want=%0d", resp_freq, FREQ); else passes++;
        rst = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b1) $display("FAIL release_req_ready got=%b want=1", req_ready); else passes++;
        $display("test_reset done");
    endtask

    task automatic test_latency();
        cycle_count = 64'd100;
        req_valid = 1'b1;
        #1;
        checks++; if (resp_valid !== 1'b0) $display("FAIL latency_no_bypass got=%b want=0", resp_valid); else passes++;
        cycle();
        req_valid = 1'b0;
        checks++; if (resp_valid !== 1'b1) $display("FAIL latency_valid got=%b want=1", resp_valid); else passes++;
        checks++; if (resp_cycle !== 64'd100) $display("FAIL latency_cycle got=%0d want=100", resp_cycle); else passes++;
        resp_ready = 1'b1;
        cycle();
        resp_ready = 1'b0;
        checks++; if (resp_valid !== 1'b0) $display("FAIL latency_pop got=%b want=0", resp_valid); else passes++;
        $display("test_latency done");
    endtask

    task automatic test_stall();
        int held_ok;
        cycle_count = 64'd200;
        req_valid = 1'b1;
        cycle();
        req_valid = 1'b0;
        held_ok = 1;
        for (int i = 0; i < 10; i++) begin
            if (resp_valid !== 1'b1 || resp_cycle !== 64'd200) begin
                held_ok = 0;
                $display("FAIL stall_hold cyc=%0d got=%0d valid=%b want=200", i, resp_cycle, resp_valid);
            end
            cycle();
        end
        checks++; if (held_ok != 1) $display("FAIL stall_hold_summary got=0 want=1"); else passes++;
        resp_ready = 1'b1;
        cycle();
        resp_ready = 1'b0;
        checks++; if (resp_valid !== 1'b0) $display("FAIL stall_pop got=%b want=0", resp_valid); else passes++;
        $display("test_stall done");
    endtask

    task automatic test_fill_drain();
        logic [63:0] n;
        n = 64'h0000_0001_0000_0000;
        cycle_count = n;
        req_valid = 1'b1;
        resp_ready = 1'b0;
        repeat (4) cycle();
        checks++; if (req_ready !== 1'b0) $display("FAIL fill_req_ready got=%b want=0", req_ready); else passes++;
        cycle();
        checks++; if (mq.size() != DEPTH) $display("FAIL fill_model_size got=%0d want=%0d", mq.size(), DEPTH); else passes++;
        req_valid = 1'b0;
        resp_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            checks++;
            if (resp_valid !== 1'b1 || resp_cycle !== n + 64'(i))
                $display("FAIL drain_%0d got=%h valid=%b want=%h", i, resp_cycle, resp_valid, n + 64'(i));
            else passes++;
            cycle();
        end
        resp_ready = 1'b0;
        checks++; if (resp_valid !== 1'b0) $display("FAIL drain_empty got=%b want=0", resp_valid); else passes++;
        $display("test_fill_drain done");
    endtask

    task automatic test_full_push_pop();
        logic [63:0] n;
        n = 64'd5000;
        cycle_count = n;
        req_valid = 1'b1;
        repeat (4) cycle();
        resp_ready = 1'b1;
        cycle();
        req_valid = 1'b0;
        resp_ready = 1'b0;
        checks++; if (req_ready !== 1'b1) $display("FAIL fullpp_req_ready got=%b want=1", req_ready); else passes++;
        checks++; if (resp_cycle !== n + 64'd1) $display("FAIL fullpp_head got=%0d want=%0d", resp_cycle, n + 64'd1); else passes++;
        resp_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            checks++;
            if (resp_valid !== 1'b1 || resp_cycle !== n + 64'(i))
                $display("FAIL fullpp_drain_%0d got=%0d valid=%b want=%0d", i, resp_cycle, resp_valid, n + 64'(i));
            else passes++;
            cycle();
        end
        resp_ready = 1'b0;
        checks++; if (resp_valid !== 1'b0) $display("FAIL fullpp_count got=%b want=0 after 3 pops", resp_valid); else passes++;
        $display("test_full_push_pop done");
    endtask

    task automatic test_wrap();
        cycle_count = 64'hFFFF_FFFF_FFFF_FFFF;
        req_valid = 1'b1;
        repeat (2) cycle();
        req_valid = 1'b0;
        resp_ready = 1'b1;
        checks++; if (resp_cycle !== 64'hFFFF_FFFF_FFFF_FFFF) $display("FAIL wrap_max got=%h want=ffffffffffffffff", resp_cycle); else passes++;
        cycle();
        checks++; if (resp_valid !== 1'b1 || resp_cycle !== 64'd0) $display("FAIL wrap_zero got=%h valid=%b want=0", resp_cycle, resp_valid); else passes++;
        cycle();
        resp_ready = 1'b0;
        $display("test_wrap done");
    endtask

    task automatic test_reset_mid();
        cycle_count = 64'd900;
        req_valid = 1'b1;
        repeat (2) cycle();
        #1;
        rst = 1'b1;
        #1;
        model_reset();
        checks++; if (resp_valid !== 1'b0) $display("FAIL rstmid_valid got=%b want=0", resp_valid); else passes++;
        checks++; if (req_ready !== 1'b0) $display("FAIL rstmid_ready got=%b want=0", req_ready); else passes++;
        repeat (3) cycle();
        checks++; if (req_ready !== 1'b0) $display("FAIL rstmid_hold_ready got=%b want=0", req_ready); else passes++;
        rst = 1'b0;
        cycle_count = 64'd1234;
        cycle();
        req_valid = 1'b0;
        checks++; if (resp_cycle !== 64'd1234) $display("FAIL rstmid_first got=%0d want=1234", resp_cycle); else passes++;
`ifdef COSIM_SNAP_SEQ_EN
        checks++; if (resp_seq !== 16'd0) $display("FAIL rstmid_seq got=%0d want=0", resp_seq); else passes++;
`endif
        resp_ready = 1'b1;
        cycle();
        resp_ready = 1'b0;
        $display("test_reset_mid done");
    endtask

    task automatic test_random();
        int errs;
        logic [63:0] exp_cycle;
        errs = 0;
        for (int i = 0; i < 400; i++) begin
            req_valid  = ($urandom_range(0, 99) < 55);
            resp_ready = ($urandom_range(0, 99) < 45);
            if ($urandom_range(0, 19) == 0) cycle_count = {$urandom, $urandom};
            #1;
            exp_cycle = (mq.size() > 0) ? mq[0] : 64'd0;
            if (req_ready !== (mq.size() < DEPTH) || resp_valid !== (mq.size() > 0) || resp_cycle !== exp_cycle) begin
                errs++;
                $display("FAIL random_%0d rdy=%b vld=%b cyc=%h want rdy=%b vld=%b cyc=%h", i, req_ready, resp_valid,
                         resp_cycle, (mq.size() < DEPTH), (mq.size() > 0), exp_cycle);
            end
`ifdef COSIM_SNAP_SEQ_EN
            if (mq.size() > 0 && resp_seq !== sq[0]) begin
                errs++;
                $display("FAIL random_seq_%0d got=%0d want=%0d", i, resp_seq, sq[0]);
            end
`endif
            cycle();
        end
        checks++; if (errs != 0) $display("FAIL random_summary errors=%0d want=0", errs); else passes++;
        req_valid = 1'b0;
        resp_ready = 1'b1;
        repeat (DEPTH + 1) cycle();
        resp_ready = 1'b0;
        checks++; if (resp_valid !== 1'b0) $display("FAIL random_drain got=%b want=0", resp_valid); else passes++;
        $display("test_random done");
    endtask

    initial begin
        test_reset();
        test_latency();
        test_stall();
        test_fill_drain();
        test_full_push_pop();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
